// File: rtl/mem_port_arbiter_if.sv
// External single-port memory bus: the arbiter drives it as master,
// the memory answers as slave with a variable-latency req/ack handshake.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        mem_type;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_type,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_type,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one external memory bus,
// with data priority, a fetch anti-starvation streak limit and an ack timeout.
module mem_port_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT         = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req,
   input  logic [ADDR_W-1:0]  if_addr,
   output logic [DATA_W-1:0]  if_rdata,
   output logic               if_ready,
   input  logic               d_ren,
   input  logic               d_wen,
   input  logic [2:0]         d_type,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [DATA_W-1:0]  d_wdata,
   output logic [DATA_W-1:0]  d_rdata,
   output logic               d_ready,
   mem_port_arbiter_if.master mem,
   output logic               mem_err,
   output logic               pl_stall
);
   localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
   localparam int TMO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
   localparam logic [TMO_W-1:0]    TMO_LIMIT  = TMO_W'(TIMEOUT);
   localparam logic [2:0]          TYPE_WORD  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_IF = 2'd1,
      ST_WAIT_D  = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [2:0]          mem_type_q, mem_type_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                if_ready_q, if_ready_d;
   logic                d_ready_q, d_ready_d;
   logic                mem_err_q, mem_err_d;

   logic                d_req_s;
   logic                fetch_blocked_s;
   logic                tmo_hit_s;

   assign d_req_s = d_ren | d_wen;

   // State register and registered outputs, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         streak_q    <= {STREAK_W{1'b0}};
         tmo_cnt_q   <= {TMO_W{1'b0}};
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         mem_type_q  <= 3'b000;
         if_rdata_q  <= {DATA_W{1'b0}};
         d_rdata_q   <= {DATA_W{1'b0}};
         if_ready_q  <= 1'b0;
         d_ready_q   <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         tmo_cnt_q   <= tmo_cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_type_q  <= mem_type_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_ready_q  <= if_ready_d;
         d_ready_q   <= d_ready_d;
         mem_err_q   <= mem_err_d;
      end
   end

   // Next-state logic: arbitration in IDLE, ack/timeout handling in WAIT_*.
   always_comb begin
      state_d         = state_q;
      streak_d        = streak_q;
      tmo_cnt_d       = tmo_cnt_q;
      mem_req_d       = mem_req_q;
      mem_we_d        = mem_we_q;
      mem_addr_d      = mem_addr_q;
      mem_wdata_d     = mem_wdata_q;
      mem_type_d      = mem_type_q;
      if_rdata_d      = if_rdata_q;
      d_rdata_d       = d_rdata_q;
      if_ready_d      = 1'b0;
      d_ready_d       = 1'b0;
      mem_err_d       = 1'b0;
      tmo_hit_s       = 1'b0;
      fetch_blocked_s = if_req & (streak_q == STREAK_MAX);

      case (state_q)
         ST_IDLE: begin
            if (d_req_s && !fetch_blocked_s) begin
               state_d     = ST_WAIT_D;
               tmo_cnt_d   = {TMO_W{1'b0}};
               mem_req_d   = 1'b1;
               mem_we_d    = d_wen;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_type_d  = d_type;
               // The streak only counts grants that made a pending fetch wait.
               if (!if_req) begin
                  streak_d = {STREAK_W{1'b0}};
               end else if (streak_q != STREAK_MAX) begin
                  streak_d = streak_q + STREAK_W'(1);
               end else begin
                  streak_d = streak_q;
               end
            end else if (if_req) begin
               state_d     = ST_WAIT_IF;
               streak_d    = {STREAK_W{1'b0}};
               tmo_cnt_d   = {TMO_W{1'b0}};
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = {DATA_W{1'b0}};
               mem_type_d  = TYPE_WORD;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_WAIT_IF, ST_WAIT_D: begin
            if (TIMEOUT > 0) begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end else begin
               tmo_cnt_d = tmo_cnt_q;
            end
            tmo_hit_s = (TIMEOUT > 0) && (tmo_cnt_d == TMO_LIMIT);

            // An ack in the timeout cycle still completes normally.
            if (mem.mem_ack) begin
               state_d   = ST_RESP;
               mem_req_d = 1'b0;
               if (state_q == ST_WAIT_IF) begin
                  if_rdata_d = mem.mem_rdata;
                  if_ready_d = 1'b1;
               end else begin
                  d_ready_d = 1'b1;
                  if (!mem_we_q) begin
                     d_rdata_d = mem.mem_rdata;
                  end else begin
                     d_rdata_d = d_rdata_q;
                  end
               end
            end else if (tmo_hit_s) begin
               state_d   = ST_RESP;
               mem_req_d = 1'b0;
               mem_err_d = 1'b1;
               if (state_q == ST_WAIT_IF) begin
                  if_rdata_d = {DATA_W{1'b0}};
                  if_ready_d = 1'b1;
               end else begin
                  d_rdata_d = {DATA_W{1'b0}};
                  d_ready_d = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign mem.mem_type  = mem_type_q;

   assign if_rdata = if_rdata_q;
   assign if_ready = if_ready_q;
   assign d_rdata  = d_rdata_q;
   assign d_ready  = d_ready_q;
   assign mem_err  = mem_err_q;

   // Freeze the pipeline while a request is outstanding and not completing this cycle.
   assign pl_stall = (if_req & ~if_ready_q) | (d_req_s & ~d_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a bench-side memory responder plus a scoreboard
// of expected completions, checked by one task per scenario.
module tb_mem_port_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef struct {
      bit          is_if;
      logic [31:0] data;
      bit          err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        d_ren;
   logic        d_wen;
   logic [2:0]  d_type;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_err;
   logic        pl_stall;

   int   checks    = 0;
   int   failures  = 0;
   int   ack_delay = 1;
   bit   never_ack = 1'b0;
   int   mem_cyc   = 0;
   exp_t exp_q[$];

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_STREAK(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .d_ren(d_ren), .d_wen(d_wen), .d_type(d_type), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
      .mem(mem_bus), .mem_err(mem_err), .pl_stall(pl_stall)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h00A0_0093;
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   // Memory responder: acks in the ack_delay-th cycle of mem_req.
   initial begin
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 32'h0;
      forever begin
         @(posedge clk); #1;
         if (mem_bus.mem_req === 1'b1) begin
            mem_cyc = mem_cyc + 1;
            if (!never_ack && mem_cyc == ack_delay) begin
               mem_bus.mem_ack   = 1'b1;
               mem_bus.mem_rdata = mem_model(mem_bus.mem_addr);
            end else begin
               mem_bus.mem_ack   = 1'b0;
               mem_bus.mem_rdata = 32'h0BAD_0BAD;
            end
         end else begin
            mem_cyc           = 0;
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = 32'h0BAD_0BAD;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Waits (bounded) for a ready pulse and reports what was seen; no comparison here.
   task automatic wait_ready(input int max_cyc, output bit got, output bit was_if,
                             output logic [31:0] rdata, output bit err, output bit stall_held);
      got = 1'b0; was_if = 1'b0; rdata = 32'h0; err = 1'b0; stall_held = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (if_ready === 1'b1 || d_ready === 1'b1) begin
            got    = 1'b1;
            was_if = (if_ready === 1'b1);
            rdata  = was_if ? if_rdata : d_rdata;
            err    = (mem_err === 1'b1);
            break;
         end
         if (pl_stall !== 1'b1) stall_held = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_type, mem_err, if_ready, d_ready} !== 8'h00) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=00000000",
                  {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_type, mem_err, if_ready, d_ready});
      end
      checks++;
      if ({mem_bus.mem_addr, mem_bus.mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
         failures++;
         $display("FAIL reset_data got=%h %h %h %h exp=0", mem_bus.mem_addr, mem_bus.mem_wdata, if_rdata, d_rdata);
      end
      checks++;
      if (dut.streak_q !== 3'd0 || dut.tmo_cnt_q !== 4'd0 || pl_stall !== 1'b0) begin
         failures++;
         $display("FAIL reset_counters got streak=%0d tmo=%0d stall=%b exp=0 0 0", dut.streak_q, dut.tmo_cnt_q, pl_stall);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single_fetch();
      logic [3:0] mreq_pat, stall_pat, rdy_pat;
      exp_t e;
      mreq_pat = 4'b0110; stall_pat = 4'b0111; rdy_pat = 4'b1000;
      ack_delay = 2;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h100;
      exp_q.push_back('{is_if: 1'b1, data: mem_model(32'h100), err: 1'b0});
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if ({mem_bus.mem_req, pl_stall, if_ready} !== {mreq_pat[c], stall_pat[c], rdy_pat[c]}) begin
            failures++;
            $display("FAIL fetch_c%0d req/stall/ready got=%b exp=%b", c,
                     {mem_bus.mem_req, pl_stall, if_ready}, {mreq_pat[c], stall_pat[c], rdy_pat[c]});
         end
         if (c == 1) begin
            checks++;
            if ({mem_bus.mem_type, mem_bus.mem_we, mem_bus.mem_addr} !== {3'b010, 1'b0, 32'h100}) begin
               failures++;
               $display("FAIL fetch_bus got type=%b we=%b addr=%h exp type=010 we=0 addr=00000100",
                        mem_bus.mem_type, mem_bus.mem_we, mem_bus.mem_addr);
            end
         end
         if (c == 3) begin
            e = exp_q.pop_front();
            checks++;
            if (if_rdata !== e.data) begin
               failures++;
               $display("FAIL fetch_rdata got=%h exp=%h", if_rdata, e.data);
            end
         end
      end
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic test_simultaneous();
      exp_t e;
      bit got, was_if, err, held;
      logic [31:0] rd;
      ack_delay = 1;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h104;
      d_ren = 1'b1; d_addr = 32'h2000; d_type = 3'b010;
      exp_q.push_back('{is_if: 1'b0, data: mem_model(32'h2000), err: 1'b0});
      exp_q.push_back('{is_if: 1'b1, data: mem_model(32'h104), err: 1'b0});
      @(negedge clk); @(negedge clk);
      checks++;
      if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr} !== {1'b1, 1'b0, 32'h2000}) begin
         failures++;
         $display("FAIL sim_data_first got req=%b we=%b addr=%h exp 1 0 00002000",
                  mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr);
      end
      wait_ready(10, got, was_if, rd, err, held);
      e = exp_q.pop_front();
      checks++;
      if ({got, was_if, rd, err, pl_stall} !== {1'b1, e.is_if, e.data, e.err, 1'b1}) begin
         failures++;
         $display("FAIL sim_data_done got=%b %b %h %b stall=%b exp=1 %b %h %b stall=1",
                  got, was_if, rd, err, pl_stall, e.is_if, e.data, e.err);
      end
      @(posedge clk); #1;
      d_ren = 1'b0;
      wait_ready(10, got, was_if, rd, err, held);
      e = exp_q.pop_front();
      checks++;
      if ({got, was_if, rd, err, held, pl_stall} !== {1'b1, e.is_if, e.data, e.err, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL sim_fetch_done got=%b %b %h %b held=%b stall=%b exp=1 %b %h %b held=1 stall=0",
                  got, was_if, rd, err, held, pl_stall, e.is_if, e.data, e.err);
      end
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic test_starvation();
      exp_t e;
      bit got, was_if, err, held;
      logic [31:0] rd;
      ack_delay = 1;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h200;
      d_ren = 1'b1; d_addr = 32'h4000; d_type = 3'b010;
      for (int i = 0; i < 4; i++)
         exp_q.push_back('{is_if: 1'b0, data: mem_model(32'h4000 + 32'(4 * i)), err: 1'b0});
      exp_q.push_back('{is_if: 1'b1, data: mem_model(32'h200), err: 1'b0});
      exp_q.push_back('{is_if: 1'b0, data: mem_model(32'h4010), err: 1'b0});
      for (int n = 0; n < 6; n++) begin
         wait_ready(10, got, was_if, rd, err, held);
         e = exp_q.pop_front();
         checks++;
         if ({got, was_if, rd, err} !== {1'b1, e.is_if, e.data, e.err}) begin
            failures++;
            $display("FAIL starve_grant%0d got=%b %b %h %b exp=1 %b %h %b", n, got, was_if, rd, err,
                     e.is_if, e.data, e.err);
         end
         if (n == 3) begin
            checks++;
            if (dut.streak_q !== 3'd4) begin
               failures++;
               $display("FAIL starve_streak_full got=%0d exp=4", dut.streak_q);
            end
         end
         if (n == 4) begin
            checks++;
            if (dut.streak_q !== 3'd0) begin
               failures++;
               $display("FAIL starve_streak_clear got=%0d exp=0", dut.streak_q);
            end
         end
         @(posedge clk); #1;
         if (n < 4) d_addr = 32'h4000 + 32'(4 * (n + 1));
         if (n == 4) if_req = 1'b0;
         if (n == 5) d_ren = 1'b0;
      end
   endtask

   task automatic test_store();
      exp_t e;
      int n_rdy;
      ack_delay = 5;
      n_rdy = 0;
      @(posedge clk); #1;
      d_wen = 1'b1; d_addr = 32'h3004; d_wdata = 32'hDEADBEEF; d_type = 3'b001;
      exp_q.push_back('{is_if: 1'b0, data: mem_model(32'h4010), err: 1'b0});
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (d_ready === 1'b1) n_rdy++;
         if (c >= 1 && c <= 5) begin
            checks++;
            if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_type, mem_bus.mem_addr, mem_bus.mem_wdata}
                !== {1'b1, 1'b1, 3'b001, 32'h3004, 32'hDEADBEEF}) begin
               failures++;
               $display("FAIL store_hold_c%0d got req=%b we=%b type=%b addr=%h wdata=%h exp 1 1 001 00003004 deadbeef",
                        c, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_type, mem_bus.mem_addr, mem_bus.mem_wdata);
            end
         end
         if (c == 6) begin
            e = exp_q.pop_front();
            checks++;
            if ({d_ready, mem_bus.mem_req, d_rdata} !== {1'b1, 1'b0, e.data}) begin
               failures++;
               $display("FAIL store_done got ready=%b req=%b rdata=%h exp 1 0 %h", d_ready, mem_bus.mem_req, d_rdata, e.data);
            end
            @(posedge clk); #1;
            d_wen = 1'b0;
         end
      end
      checks++;
      if (n_rdy != 1) begin
         failures++;
         $display("FAIL store_ready_count got=%0d exp=1", n_rdy);
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      logic exp_req, exp_pulse;
      for (int pass = 0; pass < 2; pass++) begin
         never_ack = (pass == 0);
         ack_delay = 8;
         @(posedge clk); #1;
         d_ren = 1'b1; d_type = 3'b010;
         d_addr = (pass == 0) ? 32'h5000 : 32'h5004;
         if (pass == 0) exp_q.push_back('{is_if: 1'b0, data: 32'h0, err: 1'b1});
         else           exp_q.push_back('{is_if: 1'b0, data: mem_model(32'h5004), err: 1'b0});
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_req   = (c >= 1 && c <= 8);
            exp_pulse = (c == 9);
            checks++;
            if ({mem_bus.mem_req, d_ready, mem_err} !== {exp_req, exp_pulse, exp_pulse && (pass == 0)}) begin
               failures++;
               $display("FAIL tmo_p%0d_c%0d req/ready/err got=%b exp=%b", pass, c,
                        {mem_bus.mem_req, d_ready, mem_err}, {exp_req, exp_pulse, exp_pulse && (pass == 0)});
            end
            if (c == 9) begin
               e = exp_q.pop_front();
               checks++;
               if (d_rdata !== e.data) begin
                  failures++;
                  $display("FAIL tmo_p%0d_rdata got=%h exp=%h", pass, d_rdata, e.data);
               end
               @(posedge clk); #1;
               d_ren = 1'b0;
               never_ack = 1'b0;
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit got, was_if, err, held;
      logic [31:0] rd;
      int n_rdy;
      n_rdy = 0;
      never_ack = 1'b1;
      @(posedge clk); #1;
      d_ren = 1'b1; d_addr = 32'h6000; d_type = 3'b010;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; d_ren = 1'b0; never_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_bus.mem_req !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_pending got req=%b exp=1", mem_bus.mem_req);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_type, mem_err, if_ready, d_ready, pl_stall} !== 9'h000 ||
          {mem_bus.mem_addr, mem_bus.mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
         failures++;
         $display("FAIL rstmid_clear got req=%b addr=%h if_rdata=%h d_rdata=%h ready=%b%b exp all zero",
                  mem_bus.mem_req, mem_bus.mem_addr, if_rdata, d_rdata, if_ready, d_ready);
      end
      repeat (3) begin
         @(negedge clk);
         if (d_ready === 1'b1 || if_ready === 1'b1) n_rdy++;
      end
      checks++;
      if (n_rdy != 0) begin
         failures++;
         $display("FAIL rstmid_no_ready got=%0d exp=0", n_rdy);
      end
      ack_delay = 1;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h108;
      exp_q.push_back('{is_if: 1'b1, data: mem_model(32'h108), err: 1'b0});
      wait_ready(10, got, was_if, rd, err, held);
      e = exp_q.pop_front();
      checks++;
      if ({got, was_if, rd, err} !== {1'b1, e.is_if, e.data, e.err}) begin
         failures++;
         $display("FAIL rstmid_refetch got=%b %b %h %b exp=1 %b %h %b", got, was_if, rd, err, e.is_if, e.data, e.err);
      end
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
      d_ren = 1'b0; d_wen = 1'b0; d_type = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_starvation();
      test_store();
      test_timeout();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external single-port memory bus between the instruction-fetch port and the load/store data port of the 5-stage pipeline.
- Each port carries one outstanding request. The external side uses a variable-latency req/ack handshake.
- Data requests have priority over fetch. A streak limit prevents fetch starvation, and a timeout guards against a memory that never acks.
- Generates the pipeline stall that freezes the PC and the pipeline registers while either port is waiting.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is pending (1..15).
- TIMEOUT, 64, cycles in WAIT without mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word, valid with if_ready.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_ren  in  1  load request (R_en), held until d_ready.
- d_wen  in  1  store request (W_en), held until d_ready.
- d_type  in  3  RW_type (byte/half/word, signed/unsigned), passed through.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, valid with d_ready.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  external request.
- mem_we  out  1  external write enable.
- mem_addr  out  ADDR_W  external address.
- mem_wdata  out  DATA_W  external write data.
- mem_type  out  3  access type; 3'b010 (word) for fetch.
- mem_ack  in  1  external completion, sampled only while mem_req=1.
- mem_rdata  in  DATA_W  external read data, valid with mem_ack.
- mem_err  out  1  one-cycle pulse on timeout abort.
- pl_stall  out  1  pipeline stall.

Behaviour:
- Reset: state=IDLE. All of the following are 0: mem_req, mem_we, mem_addr, mem_wdata, mem_type, if_rdata, d_rdata, if_ready, d_ready, mem_err, streak counter, timeout counter. Reset mid-transaction drops mem_req on the next edge; no ready pulse is issued for the aborted access.
- d_req = d_ren | d_wen. If both are set, the access is a write (mem_we=1).
- States:
  - IDLE: evaluate requests.
  - WAIT_IF: fetch in flight.
  - WAIT_D: data in flight.
  - RESP: one-cycle response; the ready pulse is asserted here.
- Arbitration in IDLE (register all mem_* outputs on grant, so mem_req rises the cycle after the request is sampled):
  - d_req and not (if_req and streak==MAX_DATA_STREAK): grant data, go to WAIT_D.
  - Else if_req: grant fetch, go to WAIT_IF.
  - Else stay in IDLE.
- Streak counter:
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant, or when if_req=0 at a data grant.
  - Saturates at MAX_DATA_STREAK.
- WAIT_*:
  - mem_req=1, with mem_addr/mem_we/mem_wdata/mem_type held stable until mem_ack.
  - On mem_ack=1: drop mem_req the next cycle; capture mem_rdata into if_rdata or d_rdata; go to RESP.
  - Stores capture nothing; d_rdata keeps its previous value.
- RESP:
  - Pulse if_ready or d_ready for exactly 1 cycle, then IDLE.
  - The requester drops or changes its request after the pulse.
  - Arbitration resumes in the IDLE cycle after RESP.
- Latency: request sampled at cycle 0, mem_req high at cycle 1, ack at cycle k≥1, ready at cycle k+1. Minimum is 2 cycles.
- Timeout (TIMEOUT>0):
  - The counter runs in WAIT_*, cleared on entry.
  - At count==TIMEOUT with no ack: drop mem_req, load zeros into the port's rdata, go to RESP, and pulse mem_err in the same cycle as the ready pulse.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no mem_err.
- pl_stall (combinational) = (if_req & ~if_ready) | (d_req & ~d_ready). It is low in the cycle a ready pulse completes the last pending request.
- Output data registers hold their value between transactions.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; memory acks 1 cycle after mem_req with 0x00A00093 -> mem_req at cycle 1, mem_type=3'b010, mem_we=0; if_ready and if_rdata=0x00A00093 at cycle 3; pl_stall high cycles 0-2, low at 3.
- Simultaneous requests: if_req and d_ren together (d_addr=0x2000, d_type=3'b010) -> data granted first (mem_addr=0x2000); fetch granted after d_ready; if_ready arrives later; pl_stall stays high until if_ready.
- Starvation: d_req continuously re-asserted with if_req held, MAX_DATA_STREAK=4 -> exactly 4 data grants, then a fetch grant, then the streak counter reads 0.
- Store: d_wen=1, d_addr=0x3004, d_wdata=0xDEADBEEF, d_type=3'b001; ack after 5 cycles -> mem_we=1, mem_wdata and mem_addr stable all 5 cycles; d_ready pulses once; d_rdata unchanged.
- Timeout: TIMEOUT=8, memory never acks -> mem_req is high for 8 cycles then drops; d_ready and mem_err pulse together; d_rdata=0. Repeat with the ack landing on the 8th cycle -> no mem_err.
- Reset mid-WAIT_D: assert rst for 1 cycle -> all outputs 0 the next cycle, no ready pulse; a new fetch then completes normally.
